// File: rtl/mult6_shiftadd.sv
// Sequential unsigned 6x6 shift-and-add multiplier.
// One carry-select adder folds the multiplicand into the upper half each step.

module carryselect (
    input  logic [5:0] a_i,
    input  logic [5:0] b_i,
    input  logic       c_i,
    output logic [5:0] s_o,
    output logic       co_o
);

    logic [3:0] lo;
    logic [3:0] hi0;
    logic [3:0] hi1;

    // Upper half is precomputed for both carries; low carry-out selects one.
    assign lo  = {1'b0, a_i[2:0]} + {1'b0, b_i[2:0]} + {3'b000, c_i};
    assign hi0 = {1'b0, a_i[5:3]} + {1'b0, b_i[5:3]};
    assign hi1 = {1'b0, a_i[5:3]} + {1'b0, b_i[5:3]} + 4'd1;

    always_comb begin
        s_o[2:0] = lo[2:0];
        if (lo[3]) begin
            s_o[5:3] = hi1[2:0];
            co_o     = hi1[3];
        end else begin
            s_o[5:3] = hi0[2:0];
            co_o     = hi0[3];
        end
    end

endmodule

module mult6_shiftadd (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  A,
    input  logic [5:0]  B,
    output logic        busy,
    output logic        done,
    output logic [11:0] Product
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  m_q, m_d;
    logic [11:0] p_q, p_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] prod_q, prod_d;
    logic        done_q, done_d;

    logic [5:0]  addend;
    logic [5:0]  sum;
    logic        co;
    logic [11:0] shifted;

    assign addend = p_q[0] ? m_q : 6'b0;

    carryselect u_add (
        .a_i  (p_q[11:6]),
        .b_i  (addend),
        .c_i  (1'b0),
        .s_o  (sum),
        .co_o (co)
    );

    // The adder carry becomes the new MSB, so no overflow is lost.
    assign shifted = {co, sum, p_q[5:1]};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = A;
                    p_d     = {6'b0, B};
                    cnt_d   = 3'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                p_d   = shifted;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    prod_d  = shifted;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= 6'b0;
            p_q     <= 12'b0;
            cnt_q   <= 3'd0;
            prod_q  <= 12'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign Product = prod_q;

endmodule

// File: tb/tb_mult6_shiftadd.sv
// Bench for mult6_shiftadd: a transaction-level model checked every
// cycle, plus directed vectors with hand-computed products.

module tb_mult6_shiftadd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  A = 6'd0;
    logic [5:0]  B = 6'd0;
    logic        busy;
    logic        done;
    logic [11:0] Product;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    mult6_shiftadd dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    always #5 clk = ~clk;

    // Model: an accepted request yields A*B, visible 6 edges later.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [11:0] m_prod = 12'd0;
    logic [11:0] m_pend = 12'd0;
    int          m_rem  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= 12'd0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_rem  <= 6;
                    m_pend <= 12'(A) * 12'(B);
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_prod <= m_pend;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [11:0] got,
                       input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_busy", {11'b0, busy}, {11'b0, m_busy});
        chk("model_done", {11'b0, done}, {11'b0, m_done});
        chk("model_prod", Product, m_prod);
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic start_op(input logic [5:0] a, input logic [5:0] b);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input logic [11:0] exp,
                             output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done expected done", nm);
        end else begin
            chk(nm, Product, exp);
        end
    endtask

    int lat;
    int d0;
    int b0;

    initial begin
        #1 rst = 1'b1;
        #12;
        chk("rst_busy", {11'b0, busy}, 12'd0);
        chk("rst_done", {11'b0, done}, 12'd0);
        chk("rst_prod", Product, 12'h000);
        @(posedge clk);
        #2 rst = 1'b0;

        // 5x7: latency, busy width, single done
        d0 = done_cnt;
        b0 = busy_cnt;
        start_op(6'd5, 6'd7);
        wait_done("p5x7", 12'h023, lat);
        chk("lat5x7", 12'(lat), 12'd6);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_width", 12'(busy_cnt - b0), 12'd6);
        chk("done_once", 12'(done_cnt - d0), 12'd1);

        start_op(6'd63, 6'd63);
        wait_done("p63x63", 12'hF81, lat);
        start_op(6'd0, 6'd42);
        wait_done("p0x42", 12'h000, lat);
        start_op(6'd42, 6'd1);
        wait_done("p42x1", 12'h02A, lat);
        start_op(6'd1, 6'd63);
        wait_done("p1x63", 12'h03F, lat);
        @(posedge clk);
        #2;

        // start while busy is ignored; operand changes ignored
        d0 = done_cnt;
        start_op(6'd3, 6'd4);
        @(posedge clk);
        #1;
        start = 1'b1;
        A = 6'd9;
        B = 6'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("p3x4", 12'h00C, lat);
        repeat (10) @(posedge clk);
        #1;
        chk("ignore_one_done", 12'(done_cnt - d0), 12'd1);

        // async reset mid-run after a prior 0x023
        start_op(6'd5, 6'd7);
        wait_done("pre_rst", 12'h023, lat);
        @(posedge clk);
        #2;
        d0 = done_cnt;
        start_op(6'd6, 6'd6);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_prod", Product, 12'h000);
        chk("arst_busy", {11'b0, busy}, 12'd0);
        chk("arst_done", {11'b0, done}, 12'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("arst_no_done", 12'(done_cnt - d0), 12'd0);
        start_op(6'd2, 6'd3);
        wait_done("p2x3", 12'h006, lat);
        @(posedge clk);
        #2;

        // back-to-back: start during done cycle
        start_op(6'd7, 6'd9);
        wait_done("p7x9", 12'h03F, lat);
        start_op(6'd10, 6'd10);
        chk("b2b_busy", {11'b0, busy}, 12'd1);
        chk("b2b_hold", Product, 12'h03F);
        wait_done("p10x10", 12'h064, lat);
        chk("lat_b2b", 12'(lat), 12'd6);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
